// File: rtl/coef_pack_loader_if.sv
// Coefficient loader bus: ROM read port plus valid/ready write port toward the operand RAM.
interface coef_pack_loader_if #(
    parameter int ELEM_W = 7,
    parameter int PACK   = 2,
    parameter int SRC_AW = 5,
    parameter int DST_AW = 4
);
    logic                     src_rd_en;
    logic [SRC_AW-1:0]        src_addr;
    logic [ELEM_W-1:0]        src_data;
    logic                     w_en;
    logic [DST_AW-1:0]        w_addr;
    logic [ELEM_W*PACK-1:0]   w_data;
    logic                     w_ready;

    // Loader side: issues ROM reads and write words
    modport master (
        output src_rd_en, src_addr,
        input  src_data,
        output w_en, w_addr, w_data,
        input  w_ready
    );

    // Memory side: ROM answers reads, destination accepts words
    modport slave (
        input  src_rd_en, src_addr,
        output src_data,
        input  w_en, w_addr, w_data,
        output w_ready
    );
endinterface

// File: rtl/coef_pack_loader.sv
// Walks a ROWS x COLS coefficient matrix from a synchronous ROM in column- or
// row-major order, packs PACK elements per word (first element in the MSBs)
// and streams the words to the operand RAM over a valid/ready write port.
module coef_pack_loader #(
    parameter int ELEM_W = 7,
    parameter int PACK   = 2,
    parameter int ROWS   = 8,
    parameter int COLS   = 4,
    parameter int SRC_AW = 5,
    parameter int DST_AW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  abort,
    output logic                  busy,
    output logic                  load_done,
    coef_pack_loader_if.master    bus
);

    localparam int NEL    = ROWS * COLS;
    localparam int NWORDS = NEL / PACK;
    localparam int WORD_W = ELEM_W * PACK;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW     = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_WRITE
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [RW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic [PW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [WORD_W-1:0]  pack_q, pack_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [SRC_AW-1:0]  src_addr_q, src_addr_d;
    logic               w_en_q, w_en_d;
    logic [DST_AW-1:0]  w_addr_q, w_addr_d;
    logic [WORD_W-1:0]  w_data_q, w_data_d;

    // Traversal position used for the next read; a run always begins at element 0
    logic               trav_mode;
    logic [RW-1:0]      base_row, row_nx;
    logic [CW-1:0]      base_col, col_nx;
    logic [SRC_AW-1:0]  cur_addr;
    logic [WORD_W-1:0]  shifted;

    // Next element position: wrapping row/col counters in the selected order
    always_comb begin
        trav_mode = (state_q == S_IDLE) ? mode : mode_q;
        base_row  = (state_q == S_IDLE) ? '0 : row_q;
        base_col  = (state_q == S_IDLE) ? '0 : col_q;
        cur_addr  = SRC_AW'(base_row) * SRC_AW'(COLS) + SRC_AW'(base_col);
        shifted   = (pack_q << ELEM_W) | WORD_W'(bus.src_data);
        row_nx    = base_row;
        col_nx    = base_col;
        if (!trav_mode) begin
            if (base_row == RW'(ROWS - 1)) begin
                row_nx = '0;
                col_nx = (base_col == CW'(COLS - 1)) ? '0 : base_col + 1'b1;
            end else begin
                row_nx = base_row + 1'b1;
            end
        end else begin
            if (base_col == CW'(COLS - 1)) begin
                col_nx = '0;
                row_nx = (base_row == RW'(ROWS - 1)) ? '0 : base_row + 1'b1;
            end else begin
                col_nx = base_col + 1'b1;
            end
        end
    end

    // Controller next state; abort overrides every transition
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        row_d      = row_q;
        col_d      = col_q;
        rd_cnt_d   = rd_cnt_q;
        pack_d     = pack_q;
        busy_d     = busy_q;
        done_d     = done_q;
        rd_en_d    = rd_en_q;
        src_addr_d = src_addr_q;
        w_en_d     = w_en_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;

        if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            rd_en_d = 1'b0;
            w_en_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_READ;
                        mode_d     = mode;
                        done_d     = 1'b0;
                        busy_d     = 1'b1;
                        w_addr_d   = '0;
                        rd_cnt_d   = '0;
                        rd_en_d    = 1'b1;
                        src_addr_d = cur_addr;
                        row_d      = row_nx;
                        col_d      = col_nx;
                    end
                end
                S_READ: begin
                    // The ROM answers one cycle late, so each READ edge captures the
                    // previous read; the leading stale element falls off the top.
                    pack_d = shifted;
                    if (rd_cnt_q == PW'(PACK - 1)) begin
                        state_d = S_LAST;
                        rd_en_d = 1'b0;
                    end else begin
                        rd_cnt_d   = rd_cnt_q + 1'b1;
                        src_addr_d = cur_addr;
                        row_d      = row_nx;
                        col_d      = col_nx;
                    end
                end
                S_LAST: begin
                    w_data_d = shifted;
                    w_en_d   = 1'b1;
                    state_d  = S_WRITE;
                end
                S_WRITE: begin
                    if (bus.w_ready) begin
                        w_en_d = 1'b0;
                        if (w_addr_q == DST_AW'(NWORDS - 1)) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = S_READ;
                            w_addr_d   = w_addr_q + 1'b1;
                            rd_cnt_d   = '0;
                            rd_en_d    = 1'b1;
                            src_addr_d = cur_addr;
                            row_d      = row_nx;
                            col_d      = col_nx;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    rd_en_d = 1'b0;
                    w_en_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            rd_cnt_q   <= '0;
            pack_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            src_addr_q <= '0;
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rd_cnt_q   <= rd_cnt_d;
            pack_q     <= pack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            src_addr_q <= src_addr_d;
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
        end
    end

    assign busy          = busy_q;
    assign load_done     = done_q;
    assign bus.src_rd_en = rd_en_q;
    assign bus.src_addr  = src_addr_q;
    assign bus.w_en      = w_en_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;

endmodule

// File: tb/tb_coef_pack_loader.sv
// Bench for coef_pack_loader: ROM model src[a]=a+1, behavioural reference of
// the expected read sequence, packed words, handshake timing and status flags.
module tb_coef_pack_loader;

    localparam int ELEM_W = 7;
    localparam int PACK   = 2;
    localparam int ROWS   = 8;
    localparam int COLS   = 4;
    localparam int SRC_AW = 5;
    localparam int DST_AW = 4;
    localparam int NEL    = ROWS * COLS;
    localparam int NW     = NEL / PACK;
    localparam int WW     = ELEM_W * PACK;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic abort = 1'b0;
    logic busy, load_done;

    coef_pack_loader_if #(.ELEM_W(ELEM_W), .PACK(PACK), .SRC_AW(SRC_AW), .DST_AW(DST_AW)) bus();

    coef_pack_loader #(
        .ELEM_W(ELEM_W), .PACK(PACK), .ROWS(ROWS), .COLS(COLS),
        .SRC_AW(SRC_AW), .DST_AW(DST_AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .load_done(load_done), .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous coefficient ROM: src[a] = a + 1
    always @(posedge clk) if (bus.src_rd_en) bus.src_data <= ELEM_W'(bus.src_addr + 1);

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [WW-1:0] exp_words [2][NW];
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    logic m_mode = 1'b0;
    int   m_rd = 0;
    int   m_hs = 0;
    int   m_edge = 0;
    int   m_last_edge = 0;
    int   hs_edges [NW];
    int   hs_raw = 0;

    function automatic int addr_of(input int md, input int e);
        int r, c;
        if (md == 0) begin r = e % ROWS; c = e / ROWS; end
        else         begin r = e / COLS; c = e % COLS; end
        return r * COLS + c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic md);
        start = 1'b1;
        mode  = md;
        tick();
        start = 1'b0;
        mode  = ~md;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            tick();
            n++;
        end
        if (m_busy) begin
            tests++;
            fails++;
            $display("FAIL %s: run still busy after %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_word(input string nm, input int idx, input int budget);
        int n = 0;
        while (!(bus.w_en === 1'b1 && int'(bus.w_addr) == idx) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s: word %0d never presented", nm, idx);
        end
    endtask

    // Per-cycle comparison against the model; predicts the state after the next edge
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", load_done, 0);
                chk("rst_rd_en", bus.src_rd_en, 0);
                chk("rst_w_en", bus.w_en, 0);
                chk("rst_src_addr", bus.src_addr, 0);
                chk("rst_w_addr", bus.w_addr, 0);
                chk("rst_w_data", bus.w_data, 0);
                m_busy = 1'b0;
                m_done = 1'b0;
                continue;
            end
            chk("busy", busy, m_busy);
            chk("load_done", load_done, m_done);
            if (!m_busy) begin
                chk("idle_rd_en", bus.src_rd_en, 0);
                chk("idle_w_en", bus.w_en, 0);
            end else begin
                if (bus.src_rd_en) begin
                    chk("read_in_range", m_rd < NEL, 1);
                    chk("src_addr", bus.src_addr, addr_of(m_mode, m_rd));
                    m_rd++;
                end
                if (bus.w_en) begin
                    chk("w_addr", bus.w_addr, m_hs);
                    chk("w_data", bus.w_data, exp_words[m_mode][m_hs]);
                    chk("reads_per_word", m_rd, (m_hs + 1) * PACK);
                end
            end
            if (bus.w_en && bus.w_ready && !abort) hs_raw++;
            m_edge++;
            if (abort) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_done = 1'b0;
                    m_mode = mode;
                    m_rd   = 0;
                    m_hs   = 0;
                    m_edge = 0;
                end
            end else if (bus.w_en && bus.w_ready) begin
                hs_edges[m_hs] = m_edge;
                m_last_edge    = m_edge;
                m_hs++;
                if (m_hs == NW) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic watchdog();
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    endtask

    initial begin
        for (int md = 0; md < 2; md++) begin
            for (int k = 0; k < NW; k++) begin
                logic [WW-1:0] w;
                w = '0;
                for (int j = 0; j < PACK; j++)
                    w = (w << ELEM_W) | WW'(addr_of(md, k * PACK + j) + 1);
                exp_words[md][k] = w;
            end
        end

        fork
            monitor();
            watchdog();
        join_none

        // Hand-computed words pin the model
        chk("model_cm_w0", exp_words[0][0], 14'h0085);
        chk("model_cm_w4", exp_words[0][4], 14'h0106);
        chk("model_rm_w0", exp_words[1][0], 14'h0082);
        chk("model_rm_w1", exp_words[1][1], 14'h0184);
        chk("model_rm_w15", exp_words[1][15], 14'h0FA0);

        bus.w_ready = 1'b1;
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_w_data", bus.w_data, 0);
        rst = 1'b1;
        tick();

        // Column-major, no backpressure
        hs_raw = 0;
        do_start(1'b0);
        wait_idle("cm_run", 200);
        chk("cm_last_edge", m_last_edge, 64);
        for (int k = 0; k < NW; k++) chk("cm_hs_edge", hs_edges[k], (k + 1) * (PACK + 2));
        tick(); tick();
        chk("cm_hs_count", hs_raw, 16);
        chk("cm_done", load_done, 1);

        // Row-major
        hs_raw = 0;
        do_start(1'b1);
        wait_idle("rm_run", 200);
        chk("rm_last_edge", m_last_edge, 64);
        tick();
        chk("rm_hs_count", hs_raw, 16);

        // Backpressure on word 2
        hs_raw = 0;
        do_start(1'b0);
        wait_word("bp_wait", 2, 50);
        bus.w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_addr", bus.w_addr, 2);
            chk("bp_hold_data", bus.w_data, exp_words[0][2]);
        end
        bus.w_ready = 1'b1;
        wait_idle("bp_run", 200);
        chk("bp_last_edge", m_last_edge, 67);
        tick();
        chk("bp_hs_count", hs_raw, 16);

        // Start while busy is ignored
        hs_raw = 0;
        do_start(1'b0);
        for (int i = 0; i < 9; i++) tick();
        start = 1'b1;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("ign_run", 200);
        chk("ign_last_edge", m_last_edge, 64);
        tick();
        chk("ign_hs_count", hs_raw, 16);

        // Abort during word 5 READ
        hs_raw = 0;
        do_start(1'b0);
        begin
            int n = 0;
            while (m_hs != 5 && n < 100) begin tick(); n++; end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", load_done, 0);
        chk("abort_w_en", bus.w_en, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("abort_hs_count", hs_raw, 5);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", busy, 0);
        hs_raw = 0;
        do_start(1'b1);
        wait_idle("post_abort_run", 200);
        chk("post_abort_last_edge", m_last_edge, 64);
        tick();
        chk("post_abort_hs_count", hs_raw, 16);

        // Asynchronous reset mid-WRITE
        hs_raw = 0;
        do_start(1'b0);
        wait_word("rst_wait", 3, 50);
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_w_en", bus.w_en, 0);
        chk("arst_rd_en", bus.src_rd_en, 0);
        chk("arst_w_addr", bus.w_addr, 0);
        chk("arst_w_data", bus.w_data, 0);
        chk("arst_src_addr", bus.src_addr, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        hs_raw = 0;
        do_start(1'b1);
        wait_idle("post_rst_run", 200);
        tick();
        chk("post_rst_hs_count", hs_raw, 16);
        chk("post_rst_done", load_done, 1);
        do_start(1'b0);
        chk("restart_clears_done", load_done, 0);
        wait_idle("restart_run", 200);
        tick();

        // Randomised runs: backpressure, stray starts, mode toggling, occasional abort
        for (int r = 0; r < 8; r++) begin
            int n = 0;
            hs_raw = 0;
            do_start(1'($urandom_range(0, 1)));
            while (m_busy && n < 2000) begin
                bus.w_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
                mode  = 1'($urandom_range(0, 1));
                abort = (r >= 5) && ($urandom_range(0, 60) == 0);
                tick();
                n++;
            end
            start = 1'b0;
            abort = 1'b0;
            bus.w_ready = 1'b1;
            if (m_busy) begin
                tests++;
                fails++;
                $display("FAIL rand_timeout: run %0d still busy", r);
            end
            tick(); tick();
            if (m_done) chk("rand_hs_count", hs_raw, 16);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coef_pack_loader.md
Name: coef_pack_loader

Overview:
- Parametrised loader that walks a ROWS x COLS coefficient matrix held in an external synchronous ROM.
- Packs PACK consecutive ELEM_W-bit elements into one write word and streams the words into a destination memory through a valid/ready write port.
- Triggered by a start pulse; traversal order (column-major or row-major) is selectable per run; reports busy/done status.
- Sits between the coefficient ROM and the matrix-engine operand RAM.

Parameters:
- ELEM_W, 7, bits per coefficient element.
- PACK, 2, elements packed per write word; ROWS*COLS must be divisible by PACK.
- ROWS, 8, matrix rows.
- COLS, 4, matrix columns.
- SRC_AW, 5, source ROM address width; 2^SRC_AW >= ROWS*COLS.
- DST_AW, 4, destination address width; 2^DST_AW >= ROWS*COLS/PACK.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load; sampled only in IDLE.
- mode  in  1  0 = column-major traversal, 1 = row-major; captured together with start.
- abort  in  1  synchronous cancel; returns to IDLE without setting load_done.
- busy  out  1  high in any state other than IDLE.
- load_done  out  1  level, set when the last word is accepted; cleared by the next accepted start.
- src_rd_en  out  1  ROM read strobe.
- src_addr  out  SRC_AW  ROM address = row*COLS + col (ROM is stored row-major).
- src_data  in  ELEM_W  ROM data, valid one cycle after src_rd_en.
- w_en  out  1  write valid.
- w_addr  out  DST_AW  word index, 0 .. ROWS*COLS/PACK-1.
- w_data  out  ELEM_W*PACK  packed word; the first-traversed element occupies the MSBs.
- w_ready  in  1  destination accepts the word at a rising edge where w_en && w_ready.

Behaviour:
- Reset: state IDLE; busy, load_done, src_rd_en and w_en are 0; src_addr, w_addr, w_data and all internal counters are 0.
- Element index e = 0 .. ROWS*COLS-1:
  - Column-major: row = e mod ROWS, col = e div ROWS.
  - Row-major: row = e div COLS, col = e mod COLS.
  - Implement both with row/col counters that wrap; no dividers.
- State machine:
  - IDLE: start=1 latches mode, clears load_done, zeroes the counters, and moves to READ.
  - READ: lasts exactly PACK cycles. src_rd_en=1 every cycle with the next element address. The element issued in the previous cycle is shifted into the pack register.
  - LAST: src_rd_en=0; captures the final element of the word; moves to WRITE.
  - WRITE: w_en=1. w_addr and w_data are held stable while w_ready=0. On handshake:
    - If this was the last word, go to IDLE and set load_done.
    - Otherwise increment w_addr and go to READ.
- Timing with w_ready held at 1 and start accepted at edge 0:
  - Word k is accepted at edge (k+1)*(PACK+2).
  - With the defaults (16 words), the last word is accepted at edge 64; load_done=1 and busy=0 from then on.
- Priority and corner cases:
  - start in a non-IDLE state is ignored.
  - abort has priority over every transition. At the next edge: IDLE, w_en=0, src_rd_en=0, load_done unchanged (stays 0 for the run in progress).
  - Simultaneous abort and start in IDLE: abort wins, start is dropped.
  - mode changes after start has no effect until the next start.
  - w_ready while w_en=0 is ignored.
  - Counters wrap only at matrix end; w_addr never exceeds ROWS*COLS/PACK-1.
  - Asynchronous reset mid-run returns every output to its reset value immediately; no partial word is written afterwards.

Test Plan:
- Test ROM: src[a]=a+1.
- Column-major, mode=0, w_ready=1:
  - word0 reads addr 0,4 -> w_data=14'h0085.
  - word4 (col 1) reads addr 1,5 -> 14'h0106, w_addr=4.
  - load_done rises after edge 64; exactly 16 handshakes occur.
- Row-major, mode=1:
  - word0 = {1,2} = 14'h0082.
  - word1 = {3,4} = 14'h0184.
  - word15 = {31,32} = 14'h0FA0.
- Backpressure: w_ready=0 for 3 cycles at word 2 -> w_addr=2 and w_data held stable; last handshake at edge 67; total handshake count still 16.
- start pulsed at cycle 10 while busy -> ignored; sequence and done timing identical to the first scenario.
- abort asserted during word 5 READ -> IDLE next edge, load_done=0, no further w_en. A new start then performs a full load from w_addr=0.
- rst low mid-WRITE -> all outputs 0 immediately. After release, a start cycle gives a clean full load. A second start after done clears load_done on the next edge.
